md5_candidate_padder: RTL and testbench

//  Downstream stage of the MD5 accelerator's candidate counter. Takes each 32-bit candidate value,

---
 rtl/md5_candidate_padder.sv | 177 +++++++++++++++++
 tb/tb_md5_candidate_padder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_candidate_padder.sv
// md5_candidate_padder
// Turns each 32-bit candidate from the counter into one MD5-padded 512-bit block. The block
// leaves as 16 little-endian 32-bit words. One prefetch slot lets the counter run one block
// ahead, so consecutive blocks are emitted with no idle cycle between them.
//
// Ports:
//   CLK, resetn        clock, asynchronous active-low reset
//   in_valid/in_ready  candidate handshake; in_data carries the candidate
//   src_done           counter exhausted (latched sticky)
//   out_valid/ready    word handshake toward the MD5 round core
//   out_word           M[out_index]; out_last flags index 15
//   out_cand           candidate that produced the current block
//   all_done           sticky: source finished and every block emitted
//   blocks_sent        blocks whose word 15 was accepted (wraps)
module md5_candidate_padder #(
    parameter int unsigned ENCODING = 0  // 0: raw 4-byte message, 1: 8-char lowercase hex
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        src_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_index,
    output logic        out_last,
    output logic [31:0] out_cand,
    output logic        all_done,
    output logic [31:0] blocks_sent
);

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] active_q, active_d;
    logic [31:0] pending_q, pending_d;
    logic        pending_full_q, pending_full_d;
    logic        src_done_q, src_done_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] blocks_q, blocks_d;

    logic accept;
    logic fire;
    logic last_fire;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};  // 0x57 + 10 = 'a'
    endfunction

    // Word idx of the padded block; byte 0 of each word sits in bits [7:0].
    function automatic logic [31:0] msg_word(input logic [31:0] cand, input logic [3:0] idx);
        logic [31:0] w;
        w = '0;
        if (ENCODING == 0) begin
            case (idx)
                4'd0:    w = cand;
                4'd1:    w = 32'h0000_0080;
                4'd14:   w = 32'h0000_0020;
                default: w = '0;
            endcase
        end else begin
            // First character is the most significant nibble.
            case (idx)
                4'd0:    w = {hex_char(cand[19:16]), hex_char(cand[23:20]),
                              hex_char(cand[27:24]), hex_char(cand[31:28])};
                4'd1:    w = {hex_char(cand[3:0]), hex_char(cand[7:4]),
                              hex_char(cand[11:8]), hex_char(cand[15:12])};
                4'd2:    w = 32'h0000_0080;
                4'd14:   w = 32'h0000_0040;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    assign out_valid   = (state_q == StEmit);
    assign all_done    = (state_q == StDone);
    assign in_ready    = resetn && !pending_full_q && (state_q != StDone);
    assign out_word    = word_q;
    assign out_index   = idx_q;
    assign out_last    = (idx_q == 4'd15);
    assign out_cand    = active_q;
    assign blocks_sent = blocks_q;

    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && (idx_q == 4'd15);

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        src_done_d     = src_done_q | src_done;
        idx_d          = idx_q;
        word_d         = word_q;
        blocks_d       = blocks_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    active_d = in_data;
                    idx_d    = 4'd0;
                    word_d   = msg_word(in_data, 4'd0);
                    state_d  = StEmit;
                end else if (src_done_q) begin
                    state_d = StDone;
                end
            end
            StEmit: begin
                if (last_fire) begin
                    blocks_d = blocks_q + 32'd1;
                    idx_d    = 4'd0;
                    if (pending_full_q) begin
                        // Promote the prefetched candidate; the slot may refill this cycle.
                        active_d       = pending_q;
                        word_d         = msg_word(pending_q, 4'd0);
                        pending_full_d = accept;
                        if (accept) begin
                            pending_d = in_data;
                        end
                    end else if (accept) begin
                        // Slot frees this cycle: load straight into ACTIVE to avoid a bubble.
                        active_d = in_data;
                        word_d   = msg_word(in_data, 4'd0);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (fire) begin
                        idx_d  = idx_q + 4'd1;
                        word_d = msg_word(active_q, idx_q + 4'd1);
                    end
                    if (accept) begin
                        pending_d      = in_data;
                        pending_full_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            src_done_q     <= 1'b0;
            idx_q          <= '0;
            word_q         <= '0;
            blocks_q       <= '0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            src_done_q     <= src_done_d;
            idx_q          <= idx_d;
            word_q         <= word_d;
            blocks_q       <= blocks_d;
        end
    end

endmodule

// File: tb/tb_md5_candidate_padder.sv
// Bench for md5_candidate_padder: one instance per encoding, shared stimulus, checked against
// a byte-level padding model and a queue of accepted candidates.
module tb_md5_candidate_padder;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        src_done = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_rdy   [2];
    logic        o_valid  [2];
    logic [31:0] o_word   [2];
    logic [3:0]  o_idx    [2];
    logic        o_last   [2];
    logic [31:0] o_cand   [2];
    logic        o_done   [2];
    logic [31:0] o_blocks [2];

    md5_candidate_padder #(.ENCODING(0)) dut0 (
        .CLK(CLK), .resetn(resetn), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .in_data(in_data), .src_done(src_done), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_word(o_word[0]), .out_index(o_idx[0]), .out_last(o_last[0]),
        .out_cand(o_cand[0]), .all_done(o_done[0]), .blocks_sent(o_blocks[0])
    );

    md5_candidate_padder #(.ENCODING(1)) dut1 (
        .CLK(CLK), .resetn(resetn), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .in_data(in_data), .src_done(src_done), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_word(o_word[1]), .out_index(o_idx[1]), .out_last(o_last[1]),
        .out_cand(o_cand[1]), .all_done(o_done[1]), .blocks_sent(o_blocks[1])
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Padded block built byte by byte: message, 0x80, zeros, 64-bit bit length (LE).
    function automatic logic [31:0] ref_word(input int enc, input logic [31:0] cand,
                                             input int idx);
        byte unsigned msg[64];
        int len;
        int bits;
        string s;
        for (int i = 0; i < 64; i++) msg[i] = 8'h00;
        if (enc == 0) begin
            len = 4;
            for (int b = 0; b < 4; b++) msg[b] = cand[8*b +: 8];
        end else begin
            s = $sformatf("%08h", cand);
            len = 8;
            for (int b = 0; b < 8; b++) msg[b] = s[b];
        end
        msg[len] = 8'h80;
        bits = len * 8;
        for (int k = 0; k < 8; k++) msg[56+k] = 8'((bits >> (8 * k)) & 255);
        return {msg[4*idx+3], msg[4*idx+2], msg[4*idx+1], msg[4*idx]};
    endfunction

    logic [31:0] exp_q[$];
    int          exp_idx = 0;
    logic [31:0] exp_blocks = '0;
    bit          src_seen = 1'b0;
    bit          rand_ready = 1'b0;
    int          cyc = 0;
    int          first_v = -1;
    int          last_v = -1;
    logic [31:0] cap[2][16];

    always @(negedge CLK) begin
        cyc++;
        if (!resetn) begin
            exp_q.delete();
            exp_idx    = 0;
            exp_blocks = '0;
            src_seen   = 1'b0;
            for (int d = 0; d < 2; d++) begin
                check_eq("rst_valid", 32'(o_valid[d]), 32'd0);
                check_eq("rst_in_ready", 32'(in_rdy[d]), 32'd0);
                check_eq("rst_blocks", o_blocks[d], 32'd0);
                check_eq("rst_all_done", 32'(o_done[d]), 32'd0);
                check_eq("rst_index", 32'(o_idx[d]), 32'd0);
                check_eq("rst_last", 32'(o_last[d]), 32'd0);
                check_eq("rst_word", o_word[d], 32'd0);
                check_eq("rst_cand", o_cand[d], 32'd0);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                check_eq("valid", 32'(o_valid[d]), 32'(exp_q.size() != 0));
                check_eq("blocks", o_blocks[d], exp_blocks);
                if (!src_seen) check_eq("in_ready", 32'(in_rdy[d]), 32'(exp_q.size() < 2));
                if (!src_seen || exp_q.size() != 0)
                    check_eq("all_done_early", 32'(o_done[d]), 32'd0);
                if (exp_q.size() != 0) begin
                    check_eq("index", 32'(o_idx[d]), 32'(exp_idx));
                    check_eq("last", 32'(o_last[d]), 32'(exp_idx == 15));
                    check_eq("cand", o_cand[d], exp_q[0]);
                    check_eq("word", o_word[d], ref_word(d, exp_q[0], exp_idx));
                    if (o_valid[d] && out_ready) cap[d][o_idx[d]] = o_word[d];
                end
            end
            if (o_valid[0]) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (exp_q.size() != 0 && out_ready) begin
                if (exp_idx == 15) begin
                    void'(exp_q.pop_front());
                    exp_idx = 0;
                    exp_blocks = exp_blocks + 32'd1;
                end else begin
                    exp_idx++;
                end
            end
            if (in_valid && in_rdy[0]) exp_q.push_back(in_data);
            if (src_done) src_seen = 1'b1;
        end
    end

    // Holds in_valid high with c until accepted; leaves in_valid asserted on return.
    task automatic send(input logic [31:0] c);
        bit ok;
        ok = 1'b0;
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_data  = c;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (in_rdy[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_in();
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !in_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        bit ok;
        fork
            forever begin
                @(posedge CLK);
                #1;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        repeat (3) @(negedge CLK);
        #2 resetn = 1'b1;

        // Raw encoding reference vector.
        send(32'h1234_5678);
        idle_in();
        wait_idle(100);
        check_eq("t1_m0", cap[0][0], 32'h1234_5678);
        check_eq("t1_m1", cap[0][1], 32'h0000_0080);
        check_eq("t1_m5", cap[0][5], 32'h0000_0000);
        check_eq("t1_m14", cap[0][14], 32'h0000_0020);
        check_eq("t1_m15", cap[0][15], 32'h0000_0000);
        check_eq("t1_blocks", o_blocks[0], 32'd1);

        // Hex encoding reference vectors.
        send(32'h0000_001F);
        idle_in();
        wait_idle(100);
        check_eq("t2_m0", cap[1][0], 32'h3030_3030);
        check_eq("t2_m1", cap[1][1], 32'h6631_3030);
        check_eq("t2_m2", cap[1][2], 32'h0000_0080);
        check_eq("t2_m14", cap[1][14], 32'h0000_0040);
        check_eq("t2_m15", cap[1][15], 32'h0000_0000);
        send(32'hFFFF_FFFF);
        idle_in();
        wait_idle(100);
        check_eq("t2_ff_m0", cap[1][0], 32'h6666_6666);
        check_eq("t2_ff_m1", cap[1][1], 32'h6666_6666);

        // Three back-to-back candidates: 48 contiguous valid cycles.
        first_v = -1;
        for (int i = 0; i < 3; i++) send($urandom);
        idle_in();
        wait_idle(200);
        check_eq("t3_span", 32'(last_v - first_v + 1), 32'd48);
        check_eq("t3_blocks", o_blocks[0], 32'd6);

        // Random backpressure and random input gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send($urandom);
            idle_in();
            repeat ($urandom_range(0, 20)) @(posedge CLK);
        end
        wait_idle(3000);
        rand_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("t4_blocks", o_blocks[0], 32'd12);

        // src_done while one block active and one pending.
        send($urandom);
        send($urandom);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        src_done = 1'b1;
        @(posedge CLK);
        #1;
        src_done = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (o_done[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("t5_done_timeout", 32'd0, 32'd1);
        for (int d = 0; d < 2; d++) begin
            check_eq("t5_all_done", 32'(o_done[d]), 32'd1);
            check_eq("t5_in_ready", 32'(in_rdy[d]), 32'd0);
            check_eq("t5_blocks", o_blocks[d], 32'd14);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check_eq("t5_ignored_valid", 32'(o_valid[d]), 32'd0);
            check_eq("t5_done_hold", 32'(o_done[d]), 32'd1);
        end
        idle_in();

        // Reset mid-block.
        @(negedge CLK);
        #2 resetn = 1'b0;
        @(negedge CLK);
        #2 resetn = 1'b1;
        send(32'hCAFE_0001);
        idle_in();
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (exp_idx == 7) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("t6_idx_timeout", 32'd0, 32'd1);
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("t6_async_valid", 32'(o_valid[d]), 32'd0);
            check_eq("t6_async_blocks", o_blocks[d], 32'd0);
            check_eq("t6_async_index", 32'(o_idx[d]), 32'd0);
            check_eq("t6_async_in_ready", 32'(in_rdy[d]), 32'd0);
        end
        repeat (2) @(negedge CLK);
        #2 resetn = 1'b1;
        c = $urandom;
        send(c);
        idle_in();
        @(negedge CLK);
        check_eq("t6_fresh_valid", 32'(o_valid[0]), 32'd1);
        check_eq("t6_fresh_index", 32'(o_idx[0]), 32'd0);
        check_eq("t6_fresh_cand", o_cand[0], c);
        wait_idle(100);
        check_eq("t6_blocks", o_blocks[0], 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
